// File: rtl/cs_pkg.sv
// cs_pkg: shared definitions for the 69-bit microcode control word.
// Holds the word width, the bit positions of every strobe field, and the
// masks derived from them:
//   CS_WE_MASK    - one-shot bits (write enables, CB toggle, bus write strobe)
//   CS_NIDLE_MASK - active-low bits, which sit high when idle
//   CS_IDLE_WORD  - the "do nothing" word
package cs_pkg;

  localparam int CS_WIDTH = 69;

  typedef logic [CS_WIDTH-1:0] cs_word_t;

  // Strobe field positions. Each field is a single bit.
  localparam int CS_STROBE_W         = 1;
  localparam int CS_DB_NWRITE_LSB    = 5;   // data bus write, active low
  localparam int CS_MAR_WE_LSB       = 24;
  localparam int CS_MDR_WE_LSB       = 31;
  localparam int CS_IR_WE_LSB        = 32;
  localparam int CS_DB_NREAD_LSB     = 35;  // data bus read, active low
  localparam int CS_PC_WE_LSB        = 42;
  localparam int CS_RF_WE_LSB        = 43;
  localparam int CS_ACC_WE_LSB       = 44;
  localparam int CS_TMP_WE_LSB       = 45;
  localparam int CS_CU_TOGGLE_CB_LSB = 48;
  localparam int CS_SP_WE_LSB        = 56;
  localparam int CS_FLAGS_WE_LSB     = 59;
  localparam int CS_CB_WE_LSB        = 60;
  localparam int CS_IO_WE_LSB        = 66;
  localparam int CS_IE_WE_LSB        = 67;
  localparam int CS_IVR_WE_LSB       = 68;

  // Mask with CS_STROBE_W ones starting at lsb.
  function automatic cs_word_t cs_field(input int lsb);
    cs_word_t m;
    m = '0;
    for (int i = 0; i < CS_STROBE_W; i++) m[lsb+i] = 1'b1;
    return m;
  endfunction

  localparam cs_word_t CS_WE_MASK =
      cs_field(CS_DB_NWRITE_LSB) | cs_field(CS_MAR_WE_LSB)   | cs_field(CS_MDR_WE_LSB)  |
      cs_field(CS_IR_WE_LSB)     | cs_field(CS_PC_WE_LSB)    | cs_field(CS_RF_WE_LSB)   |
      cs_field(CS_ACC_WE_LSB)    | cs_field(CS_TMP_WE_LSB)   | cs_field(CS_CU_TOGGLE_CB_LSB) |
      cs_field(CS_SP_WE_LSB)     | cs_field(CS_FLAGS_WE_LSB) | cs_field(CS_CB_WE_LSB)   |
      cs_field(CS_IO_WE_LSB)     | cs_field(CS_IE_WE_LSB)    | cs_field(CS_IVR_WE_LSB);

  localparam cs_word_t CS_NIDLE_MASK = cs_field(CS_DB_NWRITE_LSB) | cs_field(CS_DB_NREAD_LSB);

  localparam cs_word_t CS_IDLE_WORD = CS_NIDLE_MASK;

endpackage

// File: rtl/cs_pipe_stage.sv
// cs_pipe_stage: one word+valid pipeline register.
// Ports:
//   clk, rst             clock, async active-high reset
//   load                 capture word_in/valid_in at the next edge
//   clear                drop the valid bit at the next edge (wins over load)
//   word_in, valid_in    incoming word and its valid flag
//   word_out, valid_out  registered word and valid flag
module cs_pipe_stage #(
  parameter int           W        = 69,
  parameter logic [W-1:0] RST_WORD = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] word_in,
  input  logic         valid_in,
  output logic [W-1:0] word_out,
  output logic         valid_out
);

  logic [W-1:0] word_d, word_q;
  logic         valid_d, valid_q;

  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      word_d  = word_in;
      valid_d = valid_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q  <= RST_WORD;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word_out  = word_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/cs_word_pipe.sv
// cs_word_pipe: stall-aware delivery stage between the microcode ROM and the
// field decoder. STAGES word registers shift on every non-stalled, non-flushed
// cycle. While a valid word is held by a stall, its one-shot strobes are
// neutralised after the first cycle so a held word cannot write twice.
// Ports:
//   clk, rst         clock, async active-high reset
//   cw_in, cw_valid  word from the ROM and its valid flag
//   cw_ready         word accepted when cw_valid & cw_ready
//   stall            freeze the pipeline
//   flush            discard everything in flight (wins over stall)
//   control_signals  word presented to the decoder (idle word when empty)
//   cs_valid         control_signals carries a real word
//   hold_cycles      cycles the current word has been held beyond its first
module cs_word_pipe
  import cs_pkg::*;
#(
  parameter int                  CW_WIDTH   = CS_WIDTH,
  parameter int                  STAGES     = 1,
  parameter logic [CW_WIDTH-1:0] WE_MASK    = CS_WE_MASK,
  parameter logic [CW_WIDTH-1:0] NIDLE_MASK = CS_NIDLE_MASK,
  parameter int                  HOLD_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CW_WIDTH-1:0] cw_in,
  input  logic                cw_valid,
  output logic                cw_ready,
  input  logic                stall,
  input  logic                flush,
  output logic [CW_WIDTH-1:0] control_signals,
  output logic                cs_valid,
  output logic [HOLD_W-1:0]   hold_cycles
);

  generate
    if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
      $error("cs_word_pipe: STAGES must be in 1..3");
    end
  endgenerate

  localparam logic [CW_WIDTH-1:0] IDLE_WORD = NIDLE_MASK;

  logic advance;
  assign advance  = ~stall & ~flush;
  assign cw_ready = advance & ~rst;

  logic [CW_WIDTH-1:0] stage_word [STAGES];
  logic [STAGES-1:0]   stage_valid;

  generate
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
      if (i == 0) begin : g_first
        cs_pipe_stage #(.W(CW_WIDTH), .RST_WORD(IDLE_WORD)) u_stage (
          .clk       (clk),
          .rst       (rst),
          .load      (advance),
          .clear     (flush),
          .word_in   (cw_in),
          .valid_in  (cw_valid),
          .word_out  (stage_word[i]),
          .valid_out (stage_valid[i])
        );
      end else begin : g_next
        cs_pipe_stage #(.W(CW_WIDTH), .RST_WORD(IDLE_WORD)) u_stage (
          .clk       (clk),
          .rst       (rst),
          .load      (advance),
          .clear     (flush),
          .word_in   (stage_word[i-1]),
          .valid_in  (stage_valid[i-1]),
          .word_out  (stage_word[i]),
          .valid_out (stage_valid[i])
        );
      end
    end
  endgenerate

  logic [CW_WIDTH-1:0] last_word;
  logic                last_valid;
  assign last_word  = stage_word[STAGES-1];
  assign last_valid = stage_valid[STAGES-1];

  // presented_q marks that the word in the last stage has already had its
  // one cycle of live strobes; it only survives across stalled edges.
  logic              presented_d, presented_q;
  logic [HOLD_W-1:0] hold_d, hold_q;

  always_comb begin
    presented_d = presented_q;
    hold_d      = hold_q;
    if (flush || advance) begin
      presented_d = 1'b0;
      hold_d      = '0;
    end else if (last_valid) begin
      presented_d = 1'b1;
      hold_d      = (hold_q == {HOLD_W{1'b1}}) ? hold_q : hold_q + HOLD_W'(1);
    end else begin
      presented_d = 1'b0;
      hold_d      = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presented_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      presented_q <= presented_d;
      hold_q      <= hold_d;
    end
  end

  // Held word: active-high strobes forced low, active-low strobes forced high.
  always_comb begin
    control_signals = IDLE_WORD;
    if (last_valid) begin
      if (presented_q) control_signals = (last_word & ~WE_MASK) | (WE_MASK & NIDLE_MASK);
      else             control_signals = last_word;
    end
  end

  assign cs_valid    = last_valid;
  assign hold_cycles = hold_q;

endmodule

// File: tb/tb_cs_word_pipe.sv
module tb_cs_word_pipe;

  localparam logic [68:0] IDLE = 69'h8_0000_0020;
  localparam logic [68:0] W_A  = 69'h0000_0000_0000_1111;
  localparam logic [68:0] W_B  = 69'h0000_0000_0000_2222;
  localparam logic [68:0] W_C  = 69'h0000_0000_0000_3333;
  // rf write (43), toggle_cb (48), bus write active (bit5=0), bus read active (bit35=0)
  localparam logic [68:0] W_H  = 69'h4001_0800_0000_0001;
  localparam logic [68:0] M_H  = 69'h4000_0000_0000_0021;
  localparam logic [68:0] W_A5 = 69'h0001_0000_0000_0001;
  localparam logic [68:0] W_B5 = 69'h0000_0000_0000_0002;
  localparam logic [68:0] W_X  = 69'h0000_0100_0000_0004;
  localparam logic [68:0] M_X  = 69'h0000_0100_0000_0024;
  localparam logic [68:0] W_Y  = 69'h0000_0000_0000_5555;
  localparam logic [68:0] W_Z  = 69'h0000_0000_0000_7777;
  localparam logic [68:0] W_S  = 69'h0000_0800_0000_0000;
  localparam logic [68:0] M_S  = 69'h0000_0000_0000_0020;
  localparam logic [68:0] W_T  = 69'h0001_0800_0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [68:0] cw_in;
  logic        cw_valid, stall, flush;
  logic        cw_ready, cs_valid;
  logic [68:0] control_signals;
  logic [7:0]  hold_cycles;

  cs_word_pipe #(.STAGES(2), .HOLD_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .cw_in           (cw_in),
    .cw_valid        (cw_valid),
    .cw_ready        (cw_ready),
    .stall           (stall),
    .flush           (flush),
    .control_signals (control_signals),
    .cs_valid        (cs_valid),
    .hold_cycles     (hold_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [68:0] w, input logic st, input logic fl);
    cw_valid = v;
    cw_in    = w;
    stall    = st;
    flush    = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [68:0] cs, input logic csv,
                         input logic [7:0] hold);
    chk({name, " cs"},   control_signals, cs);
    chk({name, " csv"},  {68'd0, cs_valid}, {68'd0, csv});
    chk({name, " hold"}, {61'd0, hold_cycles}, {61'd0, hold});
  endtask

  typedef struct {
    logic        v;
    logic [68:0] w;
    logic        st;
    logic        fl;
    logic        rdy;
    logic [68:0] cs;
    logic        csv;
    logic [7:0]  hold;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [68:0] w, input logic st,
                              input logic fl, input logic rdy, input logic [68:0] cs,
                              input logic csv, input logic [7:0] hold);
    vec_t r;
    r.v = v; r.w = w; r.st = st; r.fl = fl;
    r.rdy = rdy; r.cs = cs; r.csv = csv; r.hold = hold;
    return r;
  endfunction

  vec_t vecs [22];

  initial begin
    int toggles;
    string nm;

    //          v     w     st fl rdy  cs    csv hold   (cs/csv/hold after the edge)
    vecs[0]  = mk(1, W_A,  0, 0, 1, IDLE, 0, 0);
    vecs[1]  = mk(1, W_B,  0, 0, 1, W_A,  1, 0);
    vecs[2]  = mk(1, W_C,  0, 0, 1, W_B,  1, 0);
    vecs[3]  = mk(0, '0,   0, 0, 1, W_C,  1, 0);
    vecs[4]  = mk(0, '0,   0, 0, 1, IDLE, 0, 0);
    vecs[5]  = mk(1, W_H,  0, 0, 1, IDLE, 0, 0);
    vecs[6]  = mk(0, '0,   0, 0, 1, W_H,  1, 0);
    vecs[7]  = mk(0, '0,   1, 0, 0, M_H,  1, 1);
    vecs[8]  = mk(0, '0,   1, 0, 0, M_H,  1, 2);
    vecs[9]  = mk(0, '0,   1, 0, 0, M_H,  1, 3);
    vecs[10] = mk(0, '0,   0, 0, 1, IDLE, 0, 0);
    vecs[11] = mk(1, W_A5, 0, 0, 1, IDLE, 0, 0);
    vecs[12] = mk(0, '0,   0, 0, 1, W_A5, 1, 0);
    vecs[13] = mk(1, W_B5, 0, 0, 1, IDLE, 0, 0);
    vecs[14] = mk(0, '0,   0, 0, 1, W_B5, 1, 0);
    vecs[15] = mk(0, '0,   0, 0, 1, IDLE, 0, 0);
    vecs[16] = mk(1, W_X,  0, 0, 1, IDLE, 0, 0);
    vecs[17] = mk(1, W_Y,  0, 0, 1, W_X,  1, 0);
    vecs[18] = mk(1, W_Z,  1, 0, 0, M_X,  1, 1);
    vecs[19] = mk(1, W_Z,  1, 1, 0, IDLE, 0, 0);
    vecs[20] = mk(0, '0,   0, 0, 1, IDLE, 0, 0);
    vecs[21] = mk(0, '0,   0, 0, 1, IDLE, 0, 0);

    rst = 1'b1;
    drive(0, '0, 0, 0);
    #12;
    chk_out("reset", IDLE, 0, 0);
    chk("reset ready", {68'd0, cw_ready}, 69'd0);
    rst = 1'b0;

    toggles = 0;
    foreach (vecs[i]) begin
      nm = $sformatf("vec%0d", i);
      drive(vecs[i].v, vecs[i].w, vecs[i].st, vecs[i].fl);
      #1;
      chk({nm, " ready"}, {68'd0, cw_ready}, {68'd0, vecs[i].rdy});
      @(posedge clk);
      #1;
      chk_out(nm, vecs[i].cs, vecs[i].csv, vecs[i].hold);
      if (i >= 11 && i <= 15 && control_signals[48]) toggles++;
    end
    chk("toggle_cb once", 69'(toggles), 69'd1);

    // Long stall: hold counter saturates, then the next word fires normally.
    drive(1, W_S, 0, 0); step();
    drive(1, W_T, 0, 0); step();
    chk_out("sat first", W_S, 1, 0);
    drive(1, W_Z, 1, 0);
    for (int k = 1; k <= 300; k++) begin
      step();
      chk_out($sformatf("sat hold%0d", k), M_S, 1, (k > 255) ? 8'd255 : 8'(k));
    end
    drive(0, '0, 0, 0); step();
    chk_out("sat release", W_T, 1, 0);
    step();
    chk_out("sat drain", IDLE, 0, 0);

    // Reset asserted mid-traffic.
    drive(1, W_A, 0, 0); step();
    drive(1, W_B, 0, 0); step();
    chk_out("mid pre", W_A, 1, 0);
    drive(1, W_C, 0, 0);
    rst = 1'b1;
    #1;
    chk_out("mid async", IDLE, 0, 0);
    chk("mid ready", {68'd0, cw_ready}, 69'd0);
    step();
    chk_out("mid held", IDLE, 0, 0);
    rst = 1'b0;
    drive(0, '0, 0, 0);
    step();
    chk_out("mid after1", IDLE, 0, 0);
    step();
    chk_out("mid after2", IDLE, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
